// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: Rcon, forward/inverse S-box computed from GF(2^8)
// arithmetic, InvMixColumns multipliers and the decryptor FSM encoding.
package aes_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_KEXP  = 2'd1;
  localparam state_t ST_ARK   = 2'd2;
  localparam state_t ST_ROUND = 2'd3;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Multiplicative inverse as b^254 (squares of b^2..b^128 multiplied together); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] y;
    logic [7:0] r;
    y = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
    return s[127-8*idx -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] t [16];
  logic [127:0] mixed;
  logic [127:0] added;

  // Byte k of the state is row k%4, column k/4; InvShiftRows takes row r from column c-r.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[r+4*c] = inv_sbox(get_byte(state_in, r + 4*(((c - r) + 4) % 4))) ^ get_byte(rk, r + 4*c);
      end
    end
  end

  always_comb begin
    mixed = '0;
    added = '0;
    for (int c = 0; c < 4; c++) begin
      added[127-8*(4*c+0) -: 8] = t[4*c+0];
      added[127-8*(4*c+1) -: 8] = t[4*c+1];
      added[127-8*(4*c+2) -: 8] = t[4*c+2];
      added[127-8*(4*c+3) -: 8] = t[4*c+3];
      mixed[127-8*(4*c+0) -: 8] = mul0e(t[4*c]) ^ mul0b(t[4*c+1]) ^ mul0d(t[4*c+2]) ^ mul09(t[4*c+3]);
      mixed[127-8*(4*c+1) -: 8] = mul09(t[4*c]) ^ mul0e(t[4*c+1]) ^ mul0b(t[4*c+2]) ^ mul0d(t[4*c+3]);
      mixed[127-8*(4*c+2) -: 8] = mul0d(t[4*c]) ^ mul09(t[4*c+1]) ^ mul0e(t[4*c+2]) ^ mul0b(t[4*c+3]);
      mixed[127-8*(4*c+3) -: 8] = mul0b(t[4*c]) ^ mul0d(t[4*c+1]) ^ mul09(t[4*c+2]) ^ mul0e(t[4*c+3]);
    end
  end

  assign state_out = last ? added : mixed;

endmodule

// File: rtl/aes_cbc_decrypt.sv
// Iterative AES-128 CBC decryptor: expands the key forward to rk10, then runs
// ten inverse rounds while walking the key schedule backwards on the fly.
// Handshake: start is taken only when busy=0; done pulses once when out updates.
module aes_cbc_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         chain,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  state_t       fsm_state;
  logic [3:0]   cnt;
  logic [127:0] ct;
  logic [127:0] cv;
  logic [127:0] prev_ct;
  logic [127:0] rk;
  logic [127:0] st;
  logic [127:0] round_out;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [31:0]  sub_in;
  logic [31:0]  sub_w;

  // The four forward S-boxes serve both directions: w3 going forward, w3^w2 going back.
  assign sub_in = (fsm_state == ST_ROUND) ? (rk[31:0] ^ rk[63:32]) : rk[31:0];
  assign sub_w  = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])}
                ^ {rcon(cnt), 24'h000000};

  always_comb begin
    rk_fwd[127:96] = rk[127:96] ^ sub_w;
    rk_fwd[95:64]  = rk[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk[31:0] ^ rk_fwd[63:32];
    rk_inv[127:96] = rk[127:96] ^ sub_w;
    rk_inv[95:64]  = rk[95:64] ^ rk[127:96];
    rk_inv[63:32]  = rk[63:32] ^ rk[95:64];
    rk_inv[31:0]   = rk[31:0] ^ rk[63:32];
  end

  // In ROUND, cnt holds the Rcon index of the key being undone, so round r = cnt-1.
  aes_inv_round u_round (
    .state_in  (st),
    .rk        (rk_inv),
    .last      (cnt == 4'd1),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= ST_IDLE;
      cnt       <= 4'd0;
      ct        <= '0;
      cv        <= '0;
      prev_ct   <= '0;
      rk        <= '0;
      st        <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_state)
        ST_IDLE: begin
          if (start) begin
            ct        <= in;
            rk        <= key;
            cv        <= chain ? prev_ct : iv;
            prev_ct   <= in;
            busy      <= 1'b1;
            cnt       <= 4'd1;
            fsm_state <= ST_KEXP;
          end
        end
        ST_KEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd10) fsm_state <= ST_ARK;
          else cnt <= cnt + 4'd1;
        end
        ST_ARK: begin
          st        <= ct ^ rk;
          cnt       <= 4'd10;
          fsm_state <= ST_ROUND;
        end
        default: begin
          rk <= rk_inv;
          if (cnt == 4'd1) begin
            out       <= round_out ^ cv;
            done      <= 1'b1;
            busy      <= 1'b0;
            fsm_state <= ST_IDLE;
          end else begin
            st  <= round_out;
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_decrypt.sv
// Directed bench for aes_cbc_decrypt using NIST SP800-38A and FIPS-197 vectors.
module tb_aes_cbc_decrypt;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         chain;
  logic [127:0] key;
  logic [127:0] iv;
  logic [127:0] in;
  logic [127:0] out;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int lat;
  int extra;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] C4  = 128'h3ff1caa1681fac09120eca307586e1a7;
  localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] KF  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CF  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PF  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P1Z = 128'h6bc0bce12a459991e134741a7f9e1925;

  aes_cbc_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .chain (chain),
    .key   (key),
    .iv    (iv),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic c, input logic [127:0] k, input logic [127:0] v,
                            input logic [127:0] d);
    chain = c;
    key   = k;
    iv    = v;
    in    = d;
    start = 1'b1;
  endtask

  // Drives start for one rising edge from a negedge, then drops it.
  task automatic do_start(input logic c, input logic [127:0] k, input logic [127:0] v,
                          input logic [127:0] d);
    @(negedge clk);
    set_inputs(c, k, v, d);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after acceptance until done is seen; bounded at 40.
  task automatic wait_done(input int already, output int cycles);
    cycles = already;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    chain = 1'b0;
    key   = '0;
    iv    = '0;
    in    = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    rst_n = 1'b1;

    // SP800-38A block 1, with latency check
    do_start(1'b0, K1, IV1, C1);
    @(negedge clk);
    chk("busy_after_accept", {127'd0, busy}, 128'd1);
    wait_done(1, lat);
    chk("latency_blk1", 128'(lat), 128'd22);
    chk("out_blk1", out, P1);
    chk("busy_at_done", {127'd0, busy}, 128'd0);

    do_start(1'b1, K1, IV1, C2);
    wait_done(0, lat);
    chk("latency_blk2", 128'(lat), 128'd22);
    chk("out_blk2", out, P2);
    do_start(1'b1, K1, IV1, C3);
    wait_done(0, lat);
    chk("out_blk3", out, P3);
    do_start(1'b1, K1, IV1, C4);
    wait_done(0, lat);
    chk("out_blk4", out, P4);

    do_start(1'b0, KF, '0, CF);
    wait_done(0, lat);
    chk("latency_fips", 128'(lat), 128'd22);
    chk("out_fips", out, PF);

    // Start pulsed mid-operation with unrelated data must be ignored
    do_start(1'b0, K1, IV1, C1);
    repeat (4) @(negedge clk);
    set_inputs(1'b0, KF, '0, CF);
    @(negedge clk);
    start = 1'b0;
    key   = '0;
    in    = '0;
    wait_done(5, lat);
    chk("latency_busy_prot", 128'(lat), 128'd22);
    chk("out_busy_prot", out, P1);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("extra_done_pulses", 128'(extra), 128'd0);
    chk("out_held", out, P1);

    // Reset 10 cycles into an operation
    do_start(1'b0, K1, IV1, C1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", out, '0);
    chk("midrst_busy", {127'd0, busy}, 128'd0);
    chk("midrst_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // chain=1 after reset chains against zero, then a back-to-back start on done
    do_start(1'b1, K1, IV1, C1);
    wait_done(0, lat);
    chk("latency_after_rst", 128'(lat), 128'd22);
    chk("out_after_rst", out, P1Z);
    set_inputs(1'b1, K1, IV1, C2);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {127'd0, busy}, 128'd1);
    wait_done(1, lat);
    chk("latency_b2b", 128'(lat), 128'd22);
    chk("out_b2b", out, P2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
